// File: rtl/sl_preceptron_mac_engine.sv
// sl_preceptron_mac_engine: streaming signed dot product with a threshold compare.
// Define SL_PRECEPTRON_MAC_SAT_EN to make the accumulator saturate. Without it, the accumulator wraps.
module sl_preceptron_mac_engine #(
    parameter int DATA_WIDTH       = 8,
    parameter int WEIGHTS_WIDTH    = 8,
    parameter int MEM_ADDR_WIDTH   = 16,
    parameter int VECTOR_LENGTH    = 64,
    parameter int SUM_WIDTH        = 24,
    parameter int WEIGHT_BASE_ADDR = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic                      i_data_in_valid,
    input  logic [DATA_WIDTH-1:0]     i_data_in,
    output logic                      o_mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [WEIGHTS_WIDTH-1:0]  i_mem_rdata,
    input  logic [SUM_WIDTH-1:0]      i_cfg_threshold,
    output logic                      o_busy,
    output logic                      o_sum_valid,
    output logic [SUM_WIDTH-1:0]      o_sum_out,
    output logic                      o_comparator_out,
    output logic                      o_overflow
);
    localparam int IW = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
    localparam int PW = DATA_WIDTH + WEIGHTS_WIDTH;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]             r_state;
    logic [IW-1:0]          r_idx;
    logic [SUM_WIDTH-1:0]   r_acc;
    logic                   r_ovf_flag;
    logic [DATA_WIDTH-1:0]  r_s1_data;
    logic                   r_s1_vld;
    logic [SUM_WIDTH-1:0]   r_sum_out;
    logic                   r_cmp;
    logic                   r_ovf;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_done;
    logic                   w_add_ovf;
    logic                   w_cmp;
    logic signed [PW-1:0]   w_prod;
    logic signed [SUM_WIDTH:0] w_sum;
    logic [SUM_WIDTH-1:0]   w_acc_next;

    // A sample that arrives together with start is dropped, just as one that arrives in IDLE is.
    assign w_accept   = (r_state == RUN) && i_data_in_valid && !i_start;
    assign w_last     = r_idx == IW'(VECTOR_LENGTH - 1);
    assign w_done     = r_state == DONE;
    assign w_prod     = $signed(r_s1_data) * $signed(i_mem_rdata);
    assign w_sum      = $signed({r_acc[SUM_WIDTH-1], r_acc}) + (SUM_WIDTH + 1)'(w_prod);
    assign w_add_ovf  = w_sum[SUM_WIDTH] ^ w_sum[SUM_WIDTH-1];
`ifdef SL_PRECEPTRON_MAC_SAT_EN
    assign w_acc_next = !w_add_ovf ? w_sum[SUM_WIDTH-1:0] :
                        w_sum[SUM_WIDTH] ? {1'b1, {(SUM_WIDTH-1){1'b0}}} : {1'b0, {(SUM_WIDTH-1){1'b1}}};
`else
    assign w_acc_next = w_sum[SUM_WIDTH-1:0];
`endif
    assign w_cmp            = $signed(r_acc) >= $signed(i_cfg_threshold);
    assign o_mem_ren        = w_accept;
    assign o_mem_addr       = MEM_ADDR_WIDTH'(WEIGHT_BASE_ADDR) + MEM_ADDR_WIDTH'(r_idx);
    assign o_busy           = (r_state == RUN) || (r_state == DRAIN);
    assign o_sum_valid      = w_done;
    // The result outputs show the new values during the sum_valid cycle and hold them after it.
    assign o_sum_out        = w_done ? r_acc : r_sum_out;
    assign o_comparator_out = w_done ? w_cmp : r_cmp;
    assign o_overflow       = w_done ? r_ovf_flag : r_ovf;

    // Sequencer, stage-1 sample register and stage-2 accumulator. Start discards any product still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_acc      <= '0;
            r_ovf_flag <= 1'b0;
            r_s1_data  <= '0;
            r_s1_vld   <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept)
                r_s1_data <= i_data_in;
            if (i_start) begin
                r_state    <= RUN;
                r_idx      <= '0;
                r_acc      <= '0;
                r_ovf_flag <= 1'b0;
            end else begin
                if (r_s1_vld) begin
                    r_acc      <= w_acc_next;
                    r_ovf_flag <= r_ovf_flag | w_add_ovf;
                end
                if (w_accept)
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                r_state <= (w_accept && w_last) ? DRAIN :
                           (r_state == DRAIN)   ? DONE  :
                           w_done               ? IDLE  : r_state;
            end
        end
    end

    // Capture the published result so that it holds until the next vector completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_out <= '0;
            r_cmp     <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_done) begin
            r_sum_out <= r_acc;
            r_cmp     <= w_cmp;
            r_ovf     <= r_ovf_flag;
        end
    end
endmodule

// File: tb/tb_sl_preceptron_mac_engine.sv
// tb_sl_preceptron_mac_engine: checks a 24-bit and a 16-bit accumulator instance against a dot-product model.
module tb_sl_preceptron_mac_engine;
`ifdef SL_PRECEPTRON_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    typedef struct {
        int     s;
        int     w;
        int     thr;
        int     gap;
        longint exp_sum;
        bit     exp_cmp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic valid = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] rd24 = '0;
    logic [7:0] rd16 = '0;
    logic signed [23:0] thr = '0;
    logic [15:0] thr16 = '0;
    logic ren24, busy24, sv24, cmp24, ovf24;
    logic [15:0] addr24;
    logic signed [23:0] sum24;
    logic ren16, busy16, sv16, cmp16, ovf16;
    logic [15:0] addr16;
    logic signed [15:0] sum16;
    int samp[64];
    int wts[64];
    int checks = 0;
    int failures = 0;
    int sv_cnt = 0;
    vec_t tab[6];

    sl_preceptron_mac_engine dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_data_in_valid(valid), .i_data_in(din),
        .o_mem_ren(ren24), .o_mem_addr(addr24), .i_mem_rdata(rd24), .i_cfg_threshold(thr),
        .o_busy(busy24), .o_sum_valid(sv24), .o_sum_out(sum24), .o_comparator_out(cmp24),
        .o_overflow(ovf24)
    );

    sl_preceptron_mac_engine #(.SUM_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_data_in_valid(valid), .i_data_in(din),
        .o_mem_ren(ren16), .o_mem_addr(addr16), .i_mem_rdata(rd16), .i_cfg_threshold(thr16),
        .o_busy(busy16), .o_sum_valid(sv16), .o_sum_out(sum16), .o_comparator_out(cmp16),
        .o_overflow(ovf16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren24) rd24 <= 8'(wts[addr24[5:0]]);
        if (ren16) rd16 <= 8'(wts[addr16[5:0]]);
    end

    always @(negedge clk) if (sv24) sv_cnt++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dot product of samp/wts with an accumulator of width w that wraps or saturates after every add.
    function automatic void model(input int w, output longint s, output bit o);
        longint mx = (longint'(1) <<< (w - 1)) - 1;
        longint mn = -mx - 1;
        s = 0;
        o = 1'b0;
        for (int i = 0; i < 64; i++) begin
            s += longint'(samp[i]) * longint'(wts[i]);
            if (s > mx || s < mn) begin
                o = 1'b1;
                if (SAT) s = (s > mx) ? mx : mn;
                else s = (s > mx) ? s - (mx - mn + 1) : s + (mx - mn + 1);
            end
        end
    endfunction

    task automatic run_vec(input int gap, input int thr_in, output longint got_sum, output bit got_cmp);
        longint e24, e16;
        bit o24, o16;
        model(24, e24, o24);
        model(16, e16, o16);
        thr = 24'(thr_in);
        thr16 = 16'(thr_in);
        start = 1'b1;
        valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                valid = 1'b0;
                #1;
                chk("mem_ren_gap", longint'(ren24), 0);
                tick();
            end
            valid = 1'b1;
            din = 8'(samp[i]);
            #1;
            chk("mem_ren", longint'(ren24), 1);
            chk("mem_addr", longint'(addr24), longint'(i));
            tick();
        end
        valid = 1'b0;
        #1;
        chk("drain_busy", longint'(busy24), 1);
        chk("drain_sum_valid", longint'(sv24), 0);
        tick();
        chk("sum_valid", longint'(sv24), 1);
        chk("sum_out", longint'(sum24), e24);
        chk("comparator", longint'(cmp24), longint'(e24 >= longint'(thr_in)));
        chk("overflow", longint'(ovf24), longint'(o24));
        chk("sum16_valid", longint'(sv16), 1);
        chk("sum16_out", longint'(sum16), e16);
        chk("comparator16", longint'(cmp16), longint'(e16 >= longint'($signed(thr16))));
        chk("overflow16", longint'(ovf16), longint'(o16));
        got_sum = longint'(sum24);
        got_cmp = cmp24;
        tick();
        chk("sum_valid_pulse", longint'(sv24), 0);
        chk("idle_busy", longint'(busy24), 0);
        chk("sum_hold", longint'(sum24), got_sum);
    endtask

    initial begin
        longint gs, e;
        bit gc, o;
        int c0;
        tab[0] = '{s: 1,   w: 2,   thr: 128, gap: 0, exp_sum: 128,     exp_cmp: 1'b1};
        tab[1] = '{s: 1,   w: 2,   thr: 129, gap: 0, exp_sum: 128,     exp_cmp: 1'b0};
        tab[2] = '{s: -3,  w: 5,   thr: -960, gap: 0, exp_sum: -960,   exp_cmp: 1'b1};
        tab[3] = '{s: 1,   w: 2,   thr: 128, gap: 1, exp_sum: 128,     exp_cmp: 1'b1};
        tab[4] = '{s: 127, w: 127, thr: 0,   gap: 0, exp_sum: 1032256, exp_cmp: 1'b1};
        tab[5] = '{s: -128, w: 127, thr: -812800, gap: 2, exp_sum: -1040384, exp_cmp: 1'b0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", longint'(sum24), 0);
        chk("rst_busy", longint'(busy24), 0);
        chk("rst_sum_valid", longint'(sv24), 0);
        chk("rst_addr", longint'(addr24), 0);
        rst_n = 1'b1;
        tick();
        valid = 1'b1;
        #1;
        chk("idle_ren", longint'(ren24), 0);
        tick();
        tick();
        chk("idle_ignore_busy", longint'(busy24), 0);
        valid = 1'b0;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 64; i++) begin
                samp[i] = tab[t].s;
                wts[i] = tab[t].w;
            end
            run_vec(tab[t].gap, tab[t].thr, gs, gc);
            chk("table_sum", gs, tab[t].exp_sum);
            chk("table_cmp", longint'(gc), longint'(tab[t].exp_cmp));
        end
        for (int i = 0; i < 64; i++) begin
            samp[i] = 1;
            wts[i] = 1;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        valid = 1'b0;
        c0 = sv_cnt;
        run_vec(0, 64, gs, gc);
        chk("abort_sum", gs, 64);
        chk("abort_one_valid", longint'(sv_cnt - c0), 1);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) begin
                samp[i] = int'($urandom_range(0, 255)) - 128;
                wts[i] = int'($urandom_range(0, 255)) - 128;
            end
            model(24, e, o);
            run_vec(2, int'(e) + int'($urandom_range(0, 2)) - 1, gs, gc);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        valid = 1'b1;
        din = 8'd1;
        for (int i = 0; i < 10; i++) tick();
        c0 = sv_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum", longint'(sum24), 0);
        chk("arst_busy", longint'(busy24), 0);
        chk("arst_ren", longint'(ren24), 0);
        chk("arst_addr", longint'(addr24), 0);
        chk("arst_cmp", longint'(cmp24), 0);
        chk("arst_ovf", longint'(ovf24), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) tick();
        valid = 1'b0;
        tick();
        chk("arst_no_sum_valid", longint'(sv_cnt - c0), 0);
        chk("arst_idle", longint'(busy24), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
